// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO registers.
// Results are computed at start, staged, and committed after a fixed latency.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] md_out,
  output logic        md_stall
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     hi;
  logic [31:0]     lo;
  logic [31:0]     res_hi;
  logic [31:0]     res_lo;
  logic            wr_hilo;

  logic            op_mult;
  logic            op_multu;
  logic            op_div;
  logic            op_divu;
  logic            op_go;
  logic            div_zero;

  logic [63:0]     sprod;
  logic [63:0]     uprod;
  logic [31:0]     divisor;
  logic [31:0]     abs_a;
  logic [31:0]     abs_b;
  logic [31:0]     q_mag;
  logic [31:0]     r_mag;
  logic [31:0]     sq;
  logic [31:0]     sr;
  logic [31:0]     uq;
  logic [31:0]     ur;
  logic [31:0]     nxt_hi;
  logic [31:0]     nxt_lo;

  assign op_mult  = (md_op == OP_MULT);
  assign op_multu = (md_op == OP_MULTU);
  assign op_div   = (md_op == OP_DIV);
  assign op_divu  = (md_op == OP_DIVU);
  assign op_go    = start &
    (op_mult | op_multu | op_div | op_divu);
  assign div_zero = (rt_data == 32'd0);

  // The divisor is forced nonzero so the datapath never sees x/0;
  // the result is discarded in that case anyway.
  assign divisor = div_zero ? 32'd1 : rt_data;

  // Result datapath: products and sign-magnitude division.
  always_comb begin
    sprod = $signed({{32{rs_data[31]}}, rs_data})
          * $signed({{32{rt_data[31]}}, rt_data});
    uprod = {32'd0, rs_data} * {32'd0, rt_data};
    abs_a = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    abs_b = divisor[31] ? (32'd0 - divisor) : divisor;
    q_mag = abs_a / abs_b;
    r_mag = abs_a % abs_b;
    sq = (rs_data[31] ^ divisor[31]) ? (32'd0 - q_mag) : q_mag;
    sr = rs_data[31] ? (32'd0 - r_mag) : r_mag;
    uq = rs_data / divisor;
    ur = rs_data % divisor;
    nxt_hi = 32'd0;
    nxt_lo = 32'd0;
    unique case (1'b1)
      op_mult: begin
        nxt_hi = sprod[63:32];
        nxt_lo = sprod[31:0];
      end
      op_multu: begin
        nxt_hi = uprod[63:32];
        nxt_lo = uprod[31:0];
      end
      op_div: begin
        nxt_hi = sr;
        nxt_lo = sq;
      end
      op_divu: begin
        nxt_hi = ur;
        nxt_lo = uq;
      end
      default: begin
        nxt_hi = 32'd0;
        nxt_lo = 32'd0;
      end
    endcase
  end

  // Control FSM: latch result at start, count down, commit to HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      res_hi  <= 32'd0;
      res_lo  <= 32'd0;
      wr_hilo <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_go) begin
            res_hi  <= nxt_hi;
            res_lo  <= nxt_lo;
            wr_hilo <= ~((op_div | op_divu) & div_zero);
            cnt     <= (op_mult | op_multu) ?
                       CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy    <= 1'b1;
            state   <= RUN;
          end else if (md_op == OP_MTHI) begin
            hi <= rs_data;
          end else if (md_op == OP_MTLO) begin
            lo <= rs_data;
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            if (wr_hilo) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Read port and stall request.
  always_comb begin
    md_out = 32'd0;
    case (md_op)
      OP_MFHI: md_out = hi;
      OP_MFLO: md_out = lo;
      default: md_out = 32'd0;
    endcase
    md_stall = md_use_D & (start | busy);
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit.
// Directed table, corner sequences and random ops against a reference model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        start;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_use_D;
  logic        busy;
  logic [31:0] md_out;
  logic        md_stall;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl [7];

  md_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .md_op   (md_op),
    .start   (start),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .md_use_D(md_use_D),
    .busy    (busy),
    .md_out  (md_out),
    .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour computed with wide arithmetic.
  task automatic model(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin
        p = 64'(sa * sb);
        {m_hi, m_lo} = p;
      end
      4'd2: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p;
      end
      4'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  // Called at a negedge; reads HI and LO through md_out.
  task automatic check_hilo(input string name,
                            input logic [31:0] eh,
                            input logic [31:0] el);
    md_op = 4'd5;
    #1;
    chk({name, " hi"}, md_out, eh);
    md_op = 4'd6;
    #1;
    chk({name, " lo"}, md_out, el);
    md_op = 4'd0;
  endtask

  task automatic move_to(input logic [3:0] op,
                         input logic [31:0] v);
    md_op   = op;
    rs_data = v;
    @(negedge clk);
    md_op = 4'd0;
  endtask

  // Issues an op at a negedge and measures the busy length.
  task automatic do_op(input string name,
                       input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    md_op   = op;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy len"}, n, (op <= 4'd2) ? MC : DC);
  endtask

  initial begin
    int n;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    tbl[0] = '{4'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE};
    tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{4'd4, 32'h7, 32'h2, 32'h1, 32'h3};
    tbl[4] = '{4'd3, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD};
    tbl[5] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    tbl[6] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};

    reset    = 1'b1;
    md_op    = 4'd0;
    start    = 1'b0;
    rs_data  = 32'd0;
    rt_data  = 32'd0;
    md_use_D = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;

    chk("reset busy", busy, 0);
    check_hilo("reset", 32'd0, 32'd0);
    md_use_D = 1'b1;
    #1;
    chk("stall idle", md_stall, 0);
    md_use_D = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt);
      check_hilo($sformatf("vec%0d", i), tbl[i].hi, tbl[i].lo);
      m_hi = tbl[i].hi;
      m_lo = tbl[i].lo;
    end

    move_to(4'd7, 32'h12345678);
    check_hilo("mthi", 32'h12345678, m_lo);
    m_hi = 32'h12345678;
    do_op("divu0", 4'd4, 32'd5, 32'd0);
    check_hilo("divu0", 32'h12345678, m_lo);
    move_to(4'd8, 32'hCAFEF00D);
    m_lo = 32'hCAFEF00D;
    do_op("div0", 4'd3, 32'hFFFFFF00, 32'd0);
    check_hilo("div0", m_hi, m_lo);

    md_use_D = 1'b1;
    md_op    = 4'd1;
    rs_data  = 32'd1000;
    rt_data  = 32'hFFFFFFFD;
    start    = 1'b1;
    #1;
    n = 0;
    while (md_stall && n < 50) begin
      n++;
      @(negedge clk);
      start = 1'b0;
      md_op = 4'd0;
      #1;
    end
    chk("stall len", n, MC + 1);
    md_use_D = 1'b0;
    model(4'd1, 32'd1000, 32'hFFFFFFFD);
    check_hilo("stall mult", m_hi, m_lo);

    @(negedge clk);
    md_op   = 4'd2;
    rs_data = 32'h0000FFFF;
    rt_data = 32'h00010001;
    start   = 1'b1;
    @(negedge clk);
    md_op   = 4'd3;
    rs_data = 32'd99;
    rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    n = 2;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("restart busy len", n, MC + 1);
    model(4'd2, 32'h0000FFFF, 32'h00010001);
    check_hilo("restart", m_hi, m_lo);

    md_op   = 4'd3;
    rs_data = 32'd100;
    rt_data = 32'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset busy", busy, 0);
    check_hilo("mid reset", 32'd0, 32'd0);
    repeat (DC + 2) @(negedge clk);
    check_hilo("post reset", 32'd0, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(1, 8));
      if (rop == 4'd5 || rop == 4'd6) rop = 4'd9;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
      if (rop <= 4'd4) begin
        do_op($sformatf("rnd%0d", i), rop, ra, rb);
      end else begin
        move_to(rop, ra);
      end
      model(rop, ra, rb);
      check_hilo($sformatf("rnd%0d", i), m_hi, m_lo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
